// File: rtl/poly_demux5_loader.sv
// ============================================================================
// Module   : poly_demux5_loader
// Brief    : Deserialises a coefficient-serial polynomial into one of five
//            packed holding registers that feed the 5:1 add-path selector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef KYBER_N
`define KYBER_N 256
`endif

module poly_demux5_loader #(
   parameter int N        = `KYBER_N,
   parameter int COEFF_W  = 12,
   parameter int NUM_DEST = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           dest_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [COEFF_W-1:0]   in_coeff,
   output logic [N*COEFF_W-1:0] out0,
   output logic [N*COEFF_W-1:0] out1,
   output logic [N*COEFF_W-1:0] out2,
   output logic [N*COEFF_W-1:0] out3,
   output logic [N*COEFF_W-1:0] out4,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int               c_cnt_w    = $clog2(N);
   localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(N - 1);
   localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
   localparam logic [2:0]       c_num_dest = 3'(NUM_DEST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [c_cnt_w-1:0]     r_cnt;
   logic [2:0]             r_dest;
   logic                   r_in_ready;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;
   logic [N*COEFF_W-1:0]   r_slot [NUM_DEST];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dest     <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         for (int k = 0; k < NUM_DEST; k++) begin
            r_slot[k] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (dest_sel < c_num_dest) begin
                     r_dest     <= dest_sel;
                     r_cnt      <= '0;
                     r_state    <= S_LOAD;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (in_valid && r_in_ready) begin
                  // Only the latched slot is written; the others hold.
                  for (int k = 0; k < NUM_DEST; k++) begin
                     if (r_dest == 3'(k)) begin
                        r_slot[k][int'(r_cnt)*COEFF_W +: COEFF_W] <= in_coeff;
                     end
                  end
                  r_cnt <= r_cnt + c_one;
                  if (r_cnt == c_last) begin
                     r_state    <= S_DONE;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;
   assign out0     = r_slot[0];
   assign out1     = r_slot[1];
   assign out2     = r_slot[2];
   assign out3     = r_slot[3];
   assign out4     = r_slot[4];

endmodule

`default_nettype wire

// File: tb/tb_poly_demux5_loader.sv
// ============================================================================
// Module   : tb_poly_demux5_loader
// Brief    : Self-checking bench for poly_demux5_loader against an array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_poly_demux5_loader;

   localparam int c_n  = 256;
   localparam int c_cw = 12;
   localparam int c_pw = c_n * c_cw;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [2:0]      dest_sel = 3'd0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [c_cw-1:0] in_coeff = '0;
   logic [c_pw-1:0] out0, out1, out2, out3, out4;
   logic            busy, done, err;

   int checks = 0;
   int failures = 0;

   logic [c_cw-1:0] model [5][c_n];
   logic [c_cw-1:0] coef  [c_n];

   poly_demux5_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .dest_sel (dest_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_coeff (in_coeff),
      .out0     (out0),
      .out1     (out1),
      .out2     (out2),
      .out3     (out3),
      .out4     (out4),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   function automatic logic [c_pw-1:0] get_slot(input int s);
      case (s)
         0:       return out0;
         1:       return out1;
         2:       return out2;
         3:       return out3;
         default: return out4;
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_slot(input string tag, input int s);
      logic [c_pw-1:0] obs;
      logic [c_pw-1:0] exp;
      int first;
      obs = get_slot(s);
      first = -1;
      for (int i = 0; i < c_n; i++) begin
         exp[i*c_cw +: c_cw] = model[s][i];
         if (first < 0 && obs[i*c_cw +: c_cw] !== model[s][i]) first = i;
      end
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s slot%0d coeff%0d observed=%0h expected=%0h",
                tag, s, first, obs[first*c_cw +: c_cw], model[s][first]);
      end
   endtask

   task automatic check_all(input string tag);
      for (int s = 0; s < 5; s++) check_slot(tag, s);
   endtask

   // mode 0: gap-free, 1: toggling valid plus 20-cycle gap at coeff 100,
   // 2: gap-free with a stray start and dest_sel change mid-load.
   task automatic run_load(input int slot, input int mode, input int stop_at,
                           output int done_cyc, output int idle);
      int  idx;
      int  cyc;
      int  gap;
      bit  seen;
      bit  v;
      idx = 0; cyc = 0; gap = 0; idle = 0; seen = 0; done_cyc = -1;
      @(negedge clk);
      start    = 1'b1;
      dest_sel = 3'(slot);
      while (!seen && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (done === 1'b1) begin
            seen = 1;
            done_cyc = cyc;
         end
         if (stop_at < c_n && idx >= stop_at) break;
         if (cyc == 1) begin
            check_val("busy_in_load", 32'(busy), 32'd1);
            check_val("ready_in_load", 32'(in_ready), 32'd1);
         end
         if (seen) begin
            in_valid = 1'b0;
         end else begin
            if (mode == 2 && cyc == 50) begin
               start    = 1'b1;
               dest_sel = 3'd3;
            end
            if (mode == 2 && cyc >= 100) dest_sel = 3'd4;
            v = (idx < stop_at);
            if (mode == 1 && v) begin
               if (idx == 100 && gap < 20) begin
                  v = 0;
                  gap++;
                  if (gap == 10) check_slot("partial_visible", slot);
               end else if (cyc % 2 == 0) begin
                  v = 0;
               end
            end
            in_valid = v;
            in_coeff = v ? coef[idx] : 12'($urandom);
            if (v) begin
               model[slot][idx] = coef[idx];
               idx++;
            end else if (idx < c_n) begin
               idle++;
            end
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (stop_at == c_n && !seen) begin
         checks++;
         failures++;
         $error("FAIL done_timeout slot%0d observed=none expected=done", slot);
      end
   endtask

   initial begin
      int dc;
      int idl;

      for (int s = 0; s < 5; s++)
         for (int i = 0; i < c_n; i++) model[s][i] = '0;

      // Reset state
      #1;
      check_all("reset_zero");
      check_val("reset_busy", 32'(busy), 32'd0);
      check_val("reset_ready", 32'(in_ready), 32'd0);
      check_val("reset_done", 32'(done), 32'd0);
      check_val("reset_err", 32'(err), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // 1: slot 2 with value i, gap-free
      for (int i = 0; i < c_n; i++) coef[i] = 12'(i);
      run_load(2, 0, c_n, dc, idl);
      check_val("t1_done_cycle", 32'(dc), 32'd257);
      check_val("t1_busy_after", 32'(busy), 32'd0);
      check_val("t1_ready_after", 32'(in_ready), 32'd0);
      check_all("t1_slots");
      @(negedge clk);
      check_val("t1_done_one_cycle", 32'(done), 32'd0);

      // 2: all five slots, value (k*256+i) mod 4096
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < c_n; i++) coef[i] = 12'((k * 256 + i) % 4096);
         run_load(k, 0, c_n, dc, idl);
         check_val("t2_done_cycle", 32'(dc), 32'd257);
         check_all("t2_slots");
      end

      // 3: illegal destinations
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         start    = 1'b1;
         dest_sel = (j == 0) ? 3'd5 : 3'd7;
         @(negedge clk);
         start = 1'b0;
         check_val("t3_err_pulse", 32'(err), 32'd1);
         check_val("t3_busy_low", 32'(busy), 32'd0);
         @(negedge clk);
         check_val("t3_err_single", 32'(err), 32'd0);
         check_val("t3_busy_still_low", 32'(busy), 32'd0);
         check_all("t3_slots_unchanged");
      end

      // 4: slot 1 with toggling valid and a 20-cycle gap, random raw data
      for (int i = 0; i < c_n; i++) coef[i] = 12'($urandom);
      run_load(1, 1, c_n, dc, idl);
      check_val("t4_done_delay", 32'(dc), 32'(257 + idl));
      check_all("t4_slots");

      // 5: slot 0 with stray start to 3 and dest_sel change to 4
      for (int i = 0; i < c_n; i++) coef[i] = 12'($urandom_range(3329, 4095));
      coef[7] = 12'hFFF;
      run_load(0, 2, c_n, dc, idl);
      check_val("t5_done_cycle", 32'(dc), 32'd257);
      check_val("t5_fff_raw", 32'(out0[7*c_cw +: c_cw]), 32'hFFF);
      check_all("t5_slots");
      dest_sel = 3'd0;
      @(negedge clk);
      check_val("t5_no_restart", 32'(busy), 32'd0);

      // 6: reset after 128 coefficients into slot 4
      for (int i = 0; i < c_n; i++) coef[i] = 12'($urandom);
      run_load(4, 0, 128, dc, idl);
      check_slot("t6_partial", 4);
      #2 rst_n = 1'b0;
      #1;
      for (int s = 0; s < 5; s++)
         for (int i = 0; i < c_n; i++) model[s][i] = '0;
      check_all("t6_async_clear");
      check_val("t6_busy_clear", 32'(busy), 32'd0);
      check_val("t6_ready_clear", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < c_n; i++) coef[i] = 12'($urandom);
      run_load(4, 0, c_n, dc, idl);
      check_val("t6_reload_done", 32'(dc), 32'd257);
      check_all("t6_reload_slots");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
